commit_ctrl: RTL and testbench

COMMIT_CTRL -- requirements
Module: commit_ctrl

---
 rtl/commit_ctrl_pkg.sv | 26 ++
 rtl/commit_ctrl_if.sv | 42 ++++
 rtl/commit_ctrl.sv | 128 ++++++++++++
 tb/tb_commit_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/commit_ctrl_pkg.sv
// Shared constants and encodings for the commit controller: tag width, NULL encodings,
// head instruction classes and FSM states.
package commit_ctrl_pkg;

    localparam int         ROB_TAG_W_DEF = 5;
    localparam logic [5:0] REG_NULL      = 6'b100000;

    typedef enum logic [1:0] {
        HT_ALU    = 2'd0,
        HT_STORE  = 2'd1,
        HT_BRANCH = 2'd2,
        HT_JUMP   = 2'd3
    } head_type_e;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_STORE_WAIT = 2'd1,
        ST_FLUSH      = 2'd2
    } state_e;

    // ENTRY_NULL is the tag with only its MSB set, for any tag width.
    function automatic logic [31:0] entry_null(input int width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/commit_ctrl_if.sv
// Bundle between the ROB head / LSB / flush network and the commit controller.
// The slave modport is the commit controller's view.
interface commit_ctrl_if #(
    parameter int ROB_TAG_W = commit_ctrl_pkg::ROB_TAG_W_DEF
) ();

    logic                 rdy;
    logic                 head_valid;
    logic [ROB_TAG_W-1:0] head_entry;
    logic [1:0]           head_type;
    logic [5:0]           head_rd;
    logic [31:0]          head_value;
    logic                 head_mispredict;
    logic [31:0]          head_target;
    logic                 store_done;

    logic                 pop;
    logic                 commit_sgn;
    logic [ROB_TAG_W-1:0] rob_entry;
    logic [5:0]           rob_des;
    logic [31:0]          rob_result;
    logic                 store_req;
    logic [ROB_TAG_W-1:0] store_entry;
    logic                 rollback;
    logic [31:0]          redirect_pc;
    logic [31:0]          commit_count;

    modport master (
        output rdy, head_valid, head_entry, head_type, head_rd, head_value,
               head_mispredict, head_target, store_done,
        input  pop, commit_sgn, rob_entry, rob_des, rob_result, store_req,
               store_entry, rollback, redirect_pc, commit_count
    );

    modport slave (
        input  rdy, head_valid, head_entry, head_type, head_rd, head_value,
               head_mispredict, head_target, store_done,
        output pop, commit_sgn, rob_entry, rob_des, rob_result, store_req,
               store_entry, rollback, redirect_pc, commit_count
    );

endinterface

// File: rtl/commit_ctrl.sv
// In-order retirement of the ROB head: register writeback, store handshake with the LSB,
// and a one-cycle flush with fetch redirect on a mispredicted branch/jump.
module commit_ctrl
    import commit_ctrl_pkg::*;
#(
    parameter int ROB_TAG_W = ROB_TAG_W_DEF
) (
    input logic         clk,
    input logic         rst,
    commit_ctrl_if.slave bus
);

    localparam logic [ROB_TAG_W-1:0] ENTRY_NULL = ROB_TAG_W'(entry_null(ROB_TAG_W));

    state_e               r_state;
    logic                 r_commit_sgn;
    logic [ROB_TAG_W-1:0] r_rob_entry;
    logic [5:0]           r_rob_des;
    logic [31:0]          r_rob_result;
    logic                 r_store_req;
    logic [ROB_TAG_W-1:0] r_store_entry;
    logic                 r_rollback;
    logic [31:0]          r_redirect_pc;
    logic [31:0]          r_commit_count;

    state_e               w_next_state;
    logic                 w_pop;
    logic                 w_commit;
    logic                 w_store_start;
    logic                 w_store_end;
    logic                 w_rollback;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        w_next_state  = r_state;
        w_pop         = 1'b0;
        w_commit      = 1'b0;
        w_store_start = 1'b0;
        w_store_end   = 1'b0;
        w_rollback    = 1'b0;

        // Reset gating keeps pop low while rst is held; rdy=0 freezes everything.
        if (!rst && bus.rdy) begin
            unique case (r_state)
                ST_RUN: begin
                    if (bus.head_valid) begin
                        unique case (head_type_e'(bus.head_type))
                            HT_STORE: begin
                                w_store_start = 1'b1;
                                w_next_state  = ST_STORE_WAIT;
                            end
                            HT_BRANCH, HT_JUMP: begin
                                w_pop    = 1'b1;
                                w_commit = (bus.head_rd != REG_NULL);
                                if (bus.head_mispredict) begin
                                    w_rollback   = 1'b1;
                                    w_next_state = ST_FLUSH;
                                end
                            end
                            default: begin
                                w_pop    = 1'b1;
                                w_commit = 1'b1;
                            end
                        endcase
                    end
                end
                ST_STORE_WAIT: begin
                    if (bus.store_done) begin
                        w_pop        = 1'b1;
                        w_store_end  = 1'b1;
                        w_next_state = ST_RUN;
                    end
                end
                ST_FLUSH: w_next_state = ST_RUN;
                default:  w_next_state = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every output register has a reset value; tags reset to ENTRY_NULL, not zero.
        if (rst) begin
            r_commit_sgn   <= 1'b0;
            r_rob_entry    <= ENTRY_NULL;
            r_rob_des      <= REG_NULL;
            r_rob_result   <= 32'd0;
            r_store_req    <= 1'b0;
            r_store_entry  <= ENTRY_NULL;
            r_rollback     <= 1'b0;
            r_redirect_pc  <= 32'd0;
            r_commit_count <= 32'd0;
        end else if (bus.rdy) begin
            r_commit_sgn <= w_commit;
            r_rollback   <= w_rollback;
            if (w_commit) begin
                r_rob_entry  <= bus.head_entry;
                r_rob_des    <= bus.head_rd;
                r_rob_result <= bus.head_value;
            end
            if (w_store_start) begin
                r_store_req   <= 1'b1;
                r_store_entry <= bus.head_entry;
            end else if (w_store_end) begin
                r_store_req   <= 1'b0;
            end
            if (w_rollback) r_redirect_pc  <= bus.head_target;
            if (w_pop)      r_commit_count <= r_commit_count + 32'd1;
        end
    end

    assign bus.pop          = w_pop;
    assign bus.commit_sgn   = r_commit_sgn;
    assign bus.rob_entry    = r_rob_entry;
    assign bus.rob_des      = r_rob_des;
    assign bus.rob_result   = r_rob_result;
    assign bus.store_req    = r_store_req;
    assign bus.store_entry  = r_store_entry;
    assign bus.rollback     = r_rollback;
    assign bus.redirect_pc  = r_redirect_pc;
    assign bus.commit_count = r_commit_count;

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed bench for commit_ctrl: ALU stream, store handshake, mispredict flush,
// rdy stall and reset during a pending store.
module tb_commit_ctrl;
    import commit_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    commit_ctrl_if #(.ROB_TAG_W(5)) bus ();

    commit_ctrl #(.ROB_TAG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_head(input logic valid, input logic [4:0] tag, input logic [1:0] ty,
                              input logic [5:0] rd, input logic [31:0] val,
                              input logic mis, input logic [31:0] tgt);
        bus.head_valid      = valid;
        bus.head_entry      = tag;
        bus.head_type       = ty;
        bus.head_rd         = rd;
        bus.head_value      = val;
        bus.head_mispredict = mis;
        bus.head_target     = tgt;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".pop"},          32'(bus.pop),          32'd0);
        check({tag, ".commit_sgn"},   32'(bus.commit_sgn),   32'd0);
        check({tag, ".store_req"},    32'(bus.store_req),    32'd0);
        check({tag, ".rollback"},     32'(bus.rollback),     32'd0);
        check({tag, ".rob_entry"},    32'(bus.rob_entry),    32'h10);
        check({tag, ".store_entry"},  32'(bus.store_entry),  32'h10);
        check({tag, ".rob_des"},      32'(bus.rob_des),      32'h20);
        check({tag, ".rob_result"},   bus.rob_result,        32'd0);
        check({tag, ".redirect_pc"},  bus.redirect_pc,       32'd0);
        check({tag, ".commit_count"}, bus.commit_count,      32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.rdy        = 1'b1;
        bus.store_done = 1'b0;
        // A valid ALU head during reset must not pop.
        drive_head(1'b1, 5'd1, HT_ALU, 6'd5, 32'hA, 1'b0, 32'd0);
        #1;
        check_reset_outputs("reset");
        cyc();
        cyc();
        drive_head(1'b0, 5'd0, HT_ALU, 6'd0, 32'd0, 1'b0, 32'd0);
        rst = 1'b0;
        cyc();
        check("idle.pop", 32'(bus.pop), 32'd0);

        // Three back-to-back ALU commits
        drive_head(1'b1, 5'd1, HT_ALU, 6'd5, 32'hA, 1'b0, 32'd0);
        #1 check("alu1.pop", 32'(bus.pop), 32'd1);
        cyc();
        check("alu1.commit_sgn", 32'(bus.commit_sgn), 32'd1);
        check("alu1.rob_entry",  32'(bus.rob_entry),  32'd1);
        check("alu1.rob_des",    32'(bus.rob_des),    32'd5);
        check("alu1.rob_result", bus.rob_result,      32'hA);
        drive_head(1'b1, 5'd2, HT_ALU, 6'd6, 32'hB, 1'b0, 32'd0);
        #1 check("alu2.pop", 32'(bus.pop), 32'd1);
        cyc();
        check("alu2.commit_sgn", 32'(bus.commit_sgn), 32'd1);
        check("alu2.rob_entry",  32'(bus.rob_entry),  32'd2);
        check("alu2.rob_des",    32'(bus.rob_des),    32'd6);
        check("alu2.rob_result", bus.rob_result,      32'hB);
        drive_head(1'b1, 5'd3, HT_ALU, 6'd7, 32'hC, 1'b0, 32'd0);
        #1 check("alu3.pop", 32'(bus.pop), 32'd1);
        cyc();
        check("alu3.commit_sgn", 32'(bus.commit_sgn), 32'd1);
        check("alu3.rob_entry",  32'(bus.rob_entry),  32'd3);
        check("alu3.rob_des",    32'(bus.rob_des),    32'd7);
        check("alu3.rob_result", bus.rob_result,      32'hC);
        check("alu3.count",      bus.commit_count,    32'd3);
        drive_head(1'b0, 5'd0, HT_ALU, 6'd0, 32'd0, 1'b0, 32'd0);
        #1 check("empty.pop", 32'(bus.pop), 32'd0);
        cyc();
        check("empty.commit_sgn", 32'(bus.commit_sgn), 32'd0);
        check("empty.count",      bus.commit_count,    32'd3);

        // Store head, tag 4, store_done arrives after store_req has been high 5 cycles
        drive_head(1'b1, 5'd4, HT_STORE, REG_NULL, 32'd0, 1'b0, 32'd0);
        #1 check("st.pop0", 32'(bus.pop), 32'd0);
        cyc();
        check("st.req",        32'(bus.store_req),   32'd1);
        check("st.entry",      32'(bus.store_entry), 32'd4);
        check("st.commit_sgn", 32'(bus.commit_sgn),  32'd0);
        for (int i = 0; i < 4; i++) begin
            #1 check("st.wait_pop", 32'(bus.pop), 32'd0);
            cyc();
            check("st.wait_req", 32'(bus.store_req), 32'd1);
        end
        bus.store_done = 1'b1;
        #1 check("st.done_pop", 32'(bus.pop), 32'd1);
        cyc();
        bus.store_done = 1'b0;
        drive_head(1'b0, 5'd0, HT_ALU, 6'd0, 32'd0, 1'b0, 32'd0);
        check("st.req_drop",   32'(bus.store_req),  32'd0);
        check("st.no_commit",  32'(bus.commit_sgn), 32'd0);
        check("st.count",      bus.commit_count,    32'd4);
        #1 check("st.after_pop", 32'(bus.pop), 32'd0);

        // Mispredicted jal: tag 2, rd 1, value 0x104, target 0x200
        drive_head(1'b1, 5'd2, HT_JUMP, 6'd1, 32'h104, 1'b1, 32'h200);
        #1 check("mp.pop", 32'(bus.pop), 32'd1);
        cyc();
        check("mp.rollback",    32'(bus.rollback),   32'd1);
        check("mp.redirect_pc", bus.redirect_pc,     32'h200);
        check("mp.commit_sgn",  32'(bus.commit_sgn), 32'd1);
        check("mp.rob_entry",   32'(bus.rob_entry),  32'd2);
        check("mp.rob_des",     32'(bus.rob_des),    32'd1);
        check("mp.rob_result",  bus.rob_result,      32'h104);
        check("mp.count",       bus.commit_count,    32'd5);
        drive_head(1'b1, 5'd9, HT_ALU, 6'd3, 32'h33, 1'b0, 32'd0);
        #1 check("flush.pop", 32'(bus.pop), 32'd0);
        cyc();
        check("flush.rollback",   32'(bus.rollback),   32'd0);
        check("flush.commit_sgn", 32'(bus.commit_sgn), 32'd0);
        check("flush.count",      bus.commit_count,    32'd5);
        check("resume.pop",       32'(bus.pop),        32'd1);
        cyc();
        check("resume.rob_entry", 32'(bus.rob_entry),  32'd9);
        check("resume.count",     bus.commit_count,    32'd6);

        // Correct branch with NULL rd pops without a commit pulse
        drive_head(1'b1, 5'd10, HT_BRANCH, REG_NULL, 32'h0, 1'b0, 32'h400);
        #1 check("br.pop", 32'(bus.pop), 32'd1);
        cyc();
        check("br.commit_sgn", 32'(bus.commit_sgn), 32'd0);
        check("br.rollback",   32'(bus.rollback),   32'd0);
        check("br.rob_entry",  32'(bus.rob_entry),  32'd9);
        check("br.count",      bus.commit_count,    32'd7);

        // rd = x0 commits like any other register
        drive_head(1'b1, 5'd11, HT_ALU, 6'd0, 32'h55, 1'b0, 32'd0);
        cyc();
        check("x0.commit_sgn", 32'(bus.commit_sgn), 32'd1);
        check("x0.rob_des",    32'(bus.rob_des),    32'd0);
        check("x0.rob_result", bus.rob_result,      32'h55);

        // rdy low for 3 cycles freezes outputs, commit resumes on the first rdy=1 cycle
        drive_head(1'b1, 5'd12, HT_ALU, 6'd8, 32'h77, 1'b0, 32'd0);
        bus.rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("stall.pop", 32'(bus.pop), 32'd0);
            cyc();
            check("stall.commit_sgn", 32'(bus.commit_sgn), 32'd1);
            check("stall.rob_entry",  32'(bus.rob_entry),  32'd11);
            check("stall.count",      bus.commit_count,    32'd8);
        end
        bus.rdy = 1'b1;
        #1 check("unstall.pop", 32'(bus.pop), 32'd1);
        cyc();
        check("unstall.rob_entry",  32'(bus.rob_entry), 32'd12);
        check("unstall.rob_des",    32'(bus.rob_des),   32'd8);
        check("unstall.rob_result", bus.rob_result,     32'h77);
        check("unstall.count",      bus.commit_count,   32'd9);
        drive_head(1'b0, 5'd0, HT_ALU, 6'd0, 32'd0, 1'b0, 32'd0);
        cyc();
        check("unstall.pulse_end", 32'(bus.commit_sgn), 32'd0);

        // Reset during STORE_WAIT aborts asynchronously; a later store_done is ignored
        drive_head(1'b1, 5'd6, HT_STORE, REG_NULL, 32'd0, 1'b0, 32'd0);
        cyc();
        check("rst_st.req",   32'(bus.store_req),   32'd1);
        check("rst_st.entry", 32'(bus.store_entry), 32'd6);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_async");
        cyc();
        drive_head(1'b0, 5'd0, HT_ALU, 6'd0, 32'd0, 1'b0, 32'd0);
        rst = 1'b0;
        bus.store_done = 1'b1;
        #1 check("rst_st.late_pop", 32'(bus.pop), 32'd0);
        cyc();
        bus.store_done = 1'b0;
        check("rst_st.late_req",   32'(bus.store_req),  32'd0);
        check("rst_st.late_count", bus.commit_count,    32'd0);
        check("rst_st.late_sgn",   32'(bus.commit_sgn), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
